// File: rtl/nn_param_loader.sv
// Parameter staging for the 2-2-1 network: collects a 9-word frame into a shadow bank
// and commits it atomically. Optional weight clamping to 1.0 under NN_PARAM_CLAMP_EN.
module nn_param_loader #(
    parameter int WW = 8,
    parameter int BW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [WW-1:0] s_data,
    input  logic          s_last,
    input  logic          freeze,
    output logic [WW-1:0] w1,
    output logic [WW-1:0] w2,
    output logic [WW-1:0] w3,
    output logic [WW-1:0] w4,
    output logic [WW-1:0] w5,
    output logic [WW-1:0] w6,
    output logic [BW-1:0] bias1,
    output logic [BW-1:0] bias2,
    output logic [BW-1:0] bias3,
    output logic          params_valid,
    output logic          load_err,
    output logic          clamped
);

    typedef enum logic [1:0] {
        ST_RECV,
        ST_SKIP,
        ST_PEND
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_idx, w_idx_nxt;
    logic [WW-1:0] r_sh_w [6];
    logic [BW-1:0] r_sh_b [3];
    logic [WW-1:0] r_w [6];
    logic [BW-1:0] r_b [3];
    logic          r_pv;
    logic          r_err;
    logic          w_xfer;
    logic          w_store;
    logic          w_discard;
    logic          w_commit_now;
    logic          w_commit_pend;
    logic          w_err;
    logic [WW-1:0] w_wt_val;

`ifdef NN_PARAM_CLAMP_EN
    localparam logic [WW-1:0] ONE = {1'b1, {(WW-1){1'b0}}};
    logic w_clamp_hit;
    logic r_clamped;

    assign w_clamp_hit = (s_data > ONE);
    assign w_wt_val    = w_clamp_hit ? ONE : s_data;
    assign clamped     = r_clamped;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clamped <= 1'b0;
        end else if (w_store && (r_idx < 4'd6) && w_clamp_hit) begin
            r_clamped <= 1'b1;
        end
    end
`else
    assign w_wt_val = s_data;
    assign clamped  = 1'b0;
`endif

    assign s_ready = (r_state != ST_PEND);
    assign w_xfer  = s_valid && s_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_store       = 1'b0;
        w_discard     = 1'b0;
        w_commit_now  = 1'b0;
        w_commit_pend = 1'b0;
        w_err         = 1'b0;
        case (r_state)
            ST_RECV: begin
                if (w_xfer) begin
                    if (r_idx < 4'd8) begin
                        if (s_last) begin
                            w_err     = 1'b1;
                            w_discard = 1'b1;
                            w_idx_nxt = '0;
                        end else begin
                            w_store   = 1'b1;
                            w_idx_nxt = r_idx + 4'd1;
                        end
                    end else if (s_last) begin
                        w_idx_nxt = '0;
                        if (freeze) begin
                            w_store     = 1'b1;
                            w_state_nxt = ST_PEND;
                        end else begin
                            w_commit_now = 1'b1;
                        end
                    end else begin
                        w_err       = 1'b1;
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_SKIP;
                    end
                end
            end
            ST_SKIP: begin
                if (w_xfer && s_last) begin
                    w_state_nxt = ST_RECV;
                    w_idx_nxt   = '0;
                end
            end
            ST_PEND: begin
                if (!freeze) begin
                    w_commit_pend = 1'b1;
                    w_state_nxt   = ST_RECV;
                    w_idx_nxt     = '0;
                end
            end
            default: begin
                w_state_nxt = ST_RECV;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RECV;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 6; i++) r_sh_w[i] <= '0;
            for (int unsigned j = 0; j < 3; j++) r_sh_b[j] <= '0;
        end else if (w_discard) begin
            for (int unsigned i = 0; i < 6; i++) r_sh_w[i] <= '0;
            for (int unsigned j = 0; j < 3; j++) r_sh_b[j] <= '0;
        end else if (w_store) begin
            for (int unsigned i = 0; i < 6; i++) begin
                if (r_idx == 4'(i)) r_sh_w[i] <= w_wt_val;
            end
            for (int unsigned j = 0; j < 3; j++) begin
                if (r_idx == 4'(j + 6)) r_sh_b[j] <= s_data[BW-1:0];
            end
        end
    end

    // On a direct commit the final bias bypasses the shadow bank so all nine land together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 6; i++) r_w[i] <= '0;
            for (int unsigned j = 0; j < 3; j++) r_b[j] <= '0;
            r_pv  <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_err;
            if (w_commit_now || w_commit_pend) begin
                for (int unsigned i = 0; i < 6; i++) r_w[i] <= r_sh_w[i];
                r_b[0] <= r_sh_b[0];
                r_b[1] <= r_sh_b[1];
                r_b[2] <= w_commit_now ? s_data[BW-1:0] : r_sh_b[2];
                r_pv   <= 1'b1;
            end
        end
    end

    assign w1           = r_w[0];
    assign w2           = r_w[1];
    assign w3           = r_w[2];
    assign w4           = r_w[3];
    assign w5           = r_w[4];
    assign w6           = r_w[5];
    assign bias1        = r_b[0];
    assign bias2        = r_b[1];
    assign bias3        = r_b[2];
    assign params_valid = r_pv;
    assign load_err     = r_err;

endmodule

// File: tb/tb_nn_param_loader.sv
// Self-checking bench for nn_param_loader: directed frame table, hand sequences for
// back-to-back/reset corners, then random frames against a frame-level model.
module tb_nn_param_loader;
    localparam int WW = 8;
    localparam int BW = 3;
`ifdef NN_PARAM_CLAMP_EN
    localparam bit CLAMP_ON = 1'b1;
`else
    localparam bit CLAMP_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          freeze = 1'b0;
    logic [WW-1:0] s_data = '0;
    logic          s_ready;
    logic [WW-1:0] w1, w2, w3, w4, w5, w6;
    logic [BW-1:0] bias1, bias2, bias3;
    logic          params_valid, load_err, clamped;

    nn_param_loader #(.WW(WW), .BW(BW)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .freeze(freeze),
        .w1(w1), .w2(w2), .w3(w3), .w4(w4), .w5(w5), .w6(w6),
        .bias1(bias1), .bias2(bias2), .bias3(bias3),
        .params_valid(params_valid), .load_err(load_err), .clamped(clamped)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int err_seen = 0;
    int err_delta = 0;
    int m_w [6];
    int m_b [3];
    int m_pv = 0;
    int m_cl = 0;
    logic [7:0] fbuf [20];

    // Each cycle with load_err high counts once, so a pulse wider than one cycle shows up.
    always @(negedge clk) if (rst_n && load_err) err_seen++;

    typedef struct {
        int               len;
        bit               frz;
        logic [11:0][7:0] words;
        int               exp_err;
        logic [5:0][7:0]  exp_w;
        logic [2:0][2:0]  exp_b;
        int               exp_pv;
        int               exp_cl;
    } vec_t;

    vec_t tbl [6];

    function automatic int clampf(input int v);
        if (CLAMP_ON && v > 128) return 128;
        return v;
    endfunction

    function automatic logic [11:0][7:0] mkw(input int a0, input int a1, input int a2,
                                             input int a3, input int a4, input int a5,
                                             input int a6, input int a7, input int a8,
                                             input int fill);
        logic [11:0][7:0] r;
        r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2); r[3] = 8'(a3);
        r[4] = 8'(a4); r[5] = 8'(a5); r[6] = 8'(a6); r[7] = 8'(a7);
        r[8] = 8'(a8); r[9] = 8'(fill); r[10] = 8'(fill + 1); r[11] = 8'(fill + 2);
        return r;
    endfunction

    function automatic logic [5:0][7:0] mk6(input int a, input int b, input int c,
                                            input int d, input int e, input int f);
        logic [5:0][7:0] r;
        r[0] = 8'(a); r[1] = 8'(b); r[2] = 8'(c); r[3] = 8'(d); r[4] = 8'(e); r[5] = 8'(f);
        return r;
    endfunction

    function automatic logic [2:0][2:0] mk3(input int a, input int b, input int c);
        logic [2:0][2:0] r;
        r[0] = 3'(a); r[1] = 3'(b); r[2] = 3'(c);
        return r;
    endfunction

    function automatic int get_w(input int i);
        case (i)
            0: return int'(w1);
            1: return int'(w2);
            2: return int'(w3);
            3: return int'(w4);
            4: return int'(w5);
            default: return int'(w6);
        endcase
    endfunction

    function automatic int get_b(input int j);
        case (j)
            0: return int'(bias1);
            1: return int'(bias2);
            default: return int'(bias3);
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        for (int i = 0; i < 6; i++) chk($sformatf("%s w%0d", tag, i + 1), get_w(i), m_w[i]);
        for (int j = 0; j < 3; j++) chk($sformatf("%s bias%0d", tag, j + 1), get_b(j), m_b[j]);
        chk($sformatf("%s params_valid", tag), int'(params_valid), m_pv);
        chk($sformatf("%s clamped", tag), int'(clamped), m_cl);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_w[i] = 0;
        for (int j = 0; j < 3; j++) m_b[j] = 0;
        m_pv = 0;
        m_cl = 0;
    endtask

    // Frame-level rules: a weight is stored if it sits in slots 0..5 and is not the frame's
    // final word; only an exact 9-word frame commits.
    task automatic model_frame(input int len);
        for (int p = 0; p < 6 && p < len - 1; p++)
            if (CLAMP_ON && int'(fbuf[p]) > 128) m_cl = 1;
        if (len == 9) begin
            for (int i = 0; i < 6; i++) m_w[i] = clampf(int'(fbuf[i]));
            for (int j = 0; j < 3; j++) m_b[j] = int'(fbuf[6 + j]) % 8;
            m_pv = 1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the handshake edge.
    task automatic send_word(input logic [7:0] d, input logic last);
        int budget;
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        budget  = 0;
        while (!s_ready && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!s_ready) chk("ready timeout", int'(s_ready), 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drive_frame(input int len, input bit frz, input int maxgap);
        int e0;
        freeze = frz;
        e0 = err_seen;
        for (int p = 0; p < len; p++) begin
            send_word(fbuf[p], p == len - 1);
            if (maxgap > 0 && p < len - 1)
                repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
        end
        if (frz && len == 9) begin
            check_model("pend hold");
            chk("pend ready", int'(s_ready), 0);
            repeat (5) begin @(posedge clk); #1; end
            check_model("pend late");
            chk("pend ready late", int'(s_ready), 0);
            freeze = 1'b0;
            @(posedge clk); #1;
        end
        freeze = 1'b0;
        @(negedge clk); #1;
        err_delta = err_seen - e0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int len;
        bit frz;

        tbl[0] = '{9, 1'b0, mkw(64, 32, 128, 0, 96, 16, 1, 1, 1, 0), 0,
                   mk6(64, 32, 128, 0, 96, 16), mk3(1, 1, 1), 1, 0};
        tbl[1] = '{5, 1'b0, mkw(7, 7, 7, 7, 7, 0, 0, 0, 0, 0), 1,
                   mk6(64, 32, 128, 0, 96, 16), mk3(1, 1, 1), 1, 0};
        tbl[2] = '{9, 1'b0, mkw(10, 20, 30, 40, 50, 60, 'h0D, 'hF2, 'h07, 0), 0,
                   mk6(10, 20, 30, 40, 50, 60), mk3(5, 2, 7), 1, 0};
        tbl[3] = '{11, 1'b0, mkw(1, 2, 3, 4, 5, 6, 7, 8, 9, 10), 1,
                   mk6(10, 20, 30, 40, 50, 60), mk3(5, 2, 7), 1, 0};
        tbl[4] = '{9, 1'b1, mkw(1, 2, 3, 4, 5, 6, 6, 5, 4, 0), 0,
                   mk6(1, 2, 3, 4, 5, 6), mk3(6, 5, 4), 1, 0};
        tbl[5] = '{9, 1'b0, mkw(200, 128, 129, 255, 0, 1, 0, 0, 0, 0), 0,
                   mk6(CLAMP_ON ? 128 : 200, 128, CLAMP_ON ? 128 : 129,
                       CLAMP_ON ? 128 : 255, 0, 1), mk3(0, 0, 0), 1, int'(CLAMP_ON)};

        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_model("reset");
        chk("reset s_ready", int'(s_ready), 1);
        chk("reset load_err", int'(load_err), 0);

        for (int t = 0; t < 6; t++) begin
            for (int p = 0; p < 12; p++) fbuf[p] = tbl[t].words[p];
            drive_frame(tbl[t].len, tbl[t].frz, 0);
            chk($sformatf("vec%0d err pulses", t), err_delta, tbl[t].exp_err);
            for (int i = 0; i < 6; i++) m_w[i] = int'(tbl[t].exp_w[i]);
            for (int j = 0; j < 3; j++) m_b[j] = int'(tbl[t].exp_b[j]);
            m_pv = tbl[t].exp_pv;
            m_cl = tbl[t].exp_cl;
            check_model($sformatf("vec%0d", t));
            chk($sformatf("vec%0d s_ready", t), int'(s_ready), 1);
            @(posedge clk); #1;
        end

        // Back-to-back frames: word 0 of the second frame goes on the edge after the commit.
        fbuf[0] = 11; fbuf[1] = 22; fbuf[2] = 33; fbuf[3] = 44; fbuf[4] = 55;
        fbuf[5] = 66; fbuf[6] = 3; fbuf[7] = 4; fbuf[8] = 5;
        fbuf[9] = 100; fbuf[10] = 90; fbuf[11] = 80; fbuf[12] = 70; fbuf[13] = 60;
        fbuf[14] = 50; fbuf[15] = 8'hFF; fbuf[16] = 8'h08; fbuf[17] = 8'h09;
        e0 = err_seen;
        for (int p = 0; p < 9; p++) send_word(fbuf[p], p == 8);
        model_frame(9);
        check_model("b2b first");
        chk("b2b ready after commit", int'(s_ready), 1);
        for (int p = 0; p < 9; p++) fbuf[p] = fbuf[p + 9];
        for (int p = 0; p < 9; p++) send_word(fbuf[p], p == 8);
        model_frame(9);
        check_model("b2b second");
        @(negedge clk); #1;
        chk("b2b err pulses", err_seen - e0, 0);
        @(posedge clk); #1;

        // Reset in the middle of a frame clears everything; a fresh frame then commits.
        for (int p = 0; p < 9; p++) fbuf[p] = 8'(p * 9 + 3);
        for (int p = 0; p < 4; p++) send_word(fbuf[p], 1'b0);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_model("midrst");
        chk("midrst s_ready", int'(s_ready), 1);
        chk("midrst load_err", int'(load_err), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        drive_frame(9, 1'b0, 1);
        model_frame(9);
        chk("postrst err pulses", err_delta, 0);
        check_model("postrst");
        @(posedge clk); #1;

        for (int r = 0; r < 40; r++) begin
            len = ($urandom_range(0, 9) < 6) ? 9 : int'($urandom_range(1, 12));
            frz = ($urandom_range(0, 3) == 0);
            for (int p = 0; p < len; p++) fbuf[p] = 8'($urandom_range(0, 255));
            drive_frame(len, frz, 2);
            model_frame(len);
            chk($sformatf("rnd%0d err pulses", r), err_delta, (len != 9) ? 1 : 0);
            check_model($sformatf("rnd%0d", r));
            chk($sformatf("rnd%0d s_ready", r), int'(s_ready), 1);
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nn_param_loader.md
# nn_param_loader

Upstream parameter-staging stage for the 2-2-1 neural network. It accepts a serial valid/ready stream of nine fixed-point words: six weights followed by three biases. Words are collected in a shadow bank. The complete set is committed atomically to the registered `w1..w6` / `bias1..bias3` outputs that drive the network, so the network never sees a partially updated parameter set.

## Interface
Parameters:
- `WW`, default 8: weight word width. Weights are unsigned Q1.(WW-1), so 2^(WW-1) = 1.0.
- `BW`, default 3: bias width. A bias is taken from `s_data[BW-1:0]`.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `s_valid` input 1: stream word valid.
- `s_ready` output 1: loader can accept a word.
- `s_data` input WW: stream word.
- `s_last` input 1: marks the final word of a set.
- `freeze` input 1: network is evaluating; defers the commit.
- `w1`..`w6` output WW each: committed weights.
- `bias1`..`bias3` output BW each: committed biases.
- `params_valid` output 1: at least one complete set has been committed.
- `load_err` output 1: one-cycle pulse on a framing error.
- `clamped` output 1: sticky flag, set when any weight has been clamped (only when `NN_PARAM_CLAMP_EN` is defined).

## Operation
- A word transfers on a rising edge with `s_valid && s_ready`.
- Stream order: index 0..5 are `w1..w6`; index 6..8 are `bias1..bias3`. Bias words ignore bits above BW-1.
- States:
  - RECV: normal collection, word index `idx` 0..8.
  - SKIP: discard words until `s_last`.
  - PEND: a complete set is held, waiting for `freeze` to drop.
- RECV, `idx<8`, `!s_last`: store the word in shadow[idx]; `idx++`.
- RECV, `idx<8`, `s_last` (short frame):
  - pulse `load_err`, set `idx=0`, discard the shadow bank;
  - committed outputs are unchanged.
- RECV, `idx==8`, `s_last`:
  - if `freeze=0`: commit shadow plus this word to the outputs; set `params_valid=1`; `idx=0`; stay in RECV.
  - if `freeze=1`: store the word and go to PEND.
- RECV, `idx==8`, `!s_last` (long frame): pulse `load_err`, go to SKIP. The committed outputs are unchanged.
- SKIP: accept and drop words. On a word with `s_last`, go to RECV with `idx=0`. No further `load_err` pulse.
- PEND:
  - `s_ready=0`;
  - on the first edge with `freeze=0`, commit, set `params_valid=1`, go to RECV with `idx=0`.
- `s_ready` is 1 in RECV and SKIP, 0 in PEND. It is a decode of registered state only, with no combinational path from `s_valid`.
- `freeze` has no effect outside PEND and the final-word edge; mid-frame words are still accepted while `freeze=1`.

## Timing
- Reset values:
  - all `w*` and `bias*` = 0;
  - `params_valid=0`, `load_err=0`, `clamped=0`;
  - state RECV, `idx=0`, so `s_ready=1`.
- Reset asserted mid-frame aborts the frame and clears the shadow and committed banks.
- Commit latency:
  - new outputs are visible the cycle after the final-word handshake edge when `freeze=0`;
  - otherwise they are visible the cycle after the first edge on which PEND sees `freeze=0`.
- All nine outputs update on the same edge. No output ever mixes two sets.
- `load_err` is high for exactly one cycle, the cycle after the erroneous handshake.
- Back-to-back frames are supported with no bubble in RECV: word 0 of the next frame may transfer on the edge immediately after the commit edge.
- `s_valid` may drop between words; `idx` holds.

## Configuration
- `NN_PARAM_CLAMP_EN` defined:
  - weight words greater than 2^(WW-1) are stored as 2^(WW-1) (1.0);
  - `clamped` sets on such a store and stays set until reset.
- `NN_PARAM_CLAMP_EN` undefined:
  - weights are stored raw;
  - `clamped` is tied to 0.
- Bias handling is identical in both builds.

## Test plan
- Reset, then stream 9 words (w = 64,32,128,0,96,16; bias = 1,1,1) with `s_last` on word 9 and `freeze=0` -> the cycle after the last handshake, `w1=64 … w6=16`, `bias*=1`, `params_valid=1`, `load_err=0`.
- Stream 5 words, the 5th with `s_last` -> a single `load_err` pulse; outputs keep the previous set; the next 9-word frame commits normally.
- Stream 11 words with `s_last` only on word 11 -> `load_err` pulse after word 9, words 10–11 dropped, outputs unchanged, the next frame loads correctly.
- Hold `freeze=1` and send a full frame -> `s_ready=0` after word 9 and the outputs stay old; drop `freeze` after 5 cycles -> the whole new set appears one cycle later, then `s_ready=1`.
- Assert `rst_n=0` after word 4 of a frame -> all outputs are 0 and `params_valid=0`; a fresh full frame then commits.
- With `NN_PARAM_CLAMP_EN` defined, send w1=200 (WW=8) -> `w1=128`, `clamped=1`; without the macro -> `w1=200`, `clamped=0`.
